// File: rtl/gat_sched_pkg.sv
// Shared types for the GAT stage scheduler: stage identifiers and FSM states.
package gat_sched_pkg;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        STG_SPMM = 2'd0,
        STG_DMVM = 2'd1,
        STG_SM   = 2'd2,
        STG_AGGR = 2'd3
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERR    = 3'd4
    } sched_state_e;

endpackage

// File: rtl/gat_stage_scheduler_counter.sv
// Saturating up-counter with synchronous clear, used for per-stage cycle counts.
module sched_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Holds at all-ones once reached so long stages never read back as short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gat_stage_scheduler.sv
// Sequences SPMM -> DMVM -> softmax -> aggregation for each GAT layer, with a
// host handshake, per-stage watchdog, sticky error/spurious flags and perf counters.
module gat_stage_scheduler
    import gat_sched_pkg::*;
#(
    parameter int NUM_LAYERS     = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        layer_idx_o,
    output logic [1:0]        stage_idx_o,
    output logic [3:0]        stage_start_o,
    input  logic [3:0]        stage_done_i,
    output logic [3:0]        spurious_o,
    input  logic [1:0]        perf_sel_i,
    output logic [PERF_W-1:0] perf_cnt_o
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TCNT_W-1:0] TIMEOUT_VAL = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0] LAST_LAYER = 8'(NUM_LAYERS - 1);
    localparam logic [1:0] LAST_STAGE = 2'(STG_AGGR);

    sched_state_e state;
    logic [TCNT_W-1:0] tcnt;
    logic [PERF_W-1:0] perf [NUM_STAGES];
    logic [NUM_STAGES-1:0] perf_inc;
    logic [3:0] active_mask;
    logic [3:0] spurious_hits;
    logic active_done;
    logic timeout_hit;
    logic run_accept;
    logic flag_clear;

    assign active_mask   = 4'b0001 << stage_idx_o;
    assign active_done   = (state == ST_WAIT) && stage_done_i[stage_idx_o];
    // A done arriving in the timeout cycle takes priority over the watchdog.
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT) &&
                           (tcnt == TIMEOUT_VAL) && !active_done;
    assign run_accept    = (state == ST_IDLE) && start_i;
    assign flag_clear    = ((state == ST_IDLE) && (start_i || clear_i)) ||
                           ((state == ST_ERR) && clear_i);
    assign spurious_hits = (state == ST_WAIT) ? (stage_done_i & ~active_mask) : stage_done_i;

    assign busy_o        = (state != ST_IDLE);
    assign done_o        = (state == ST_FINISH);
    assign stage_start_o = (state == ST_LAUNCH) ? active_mask : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            layer_idx_o <= 8'd0;
            stage_idx_o <= 2'd0;
            tcnt        <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        layer_idx_o <= 8'd0;
                        stage_idx_o <= 2'd0;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (active_done) begin
                        if (stage_idx_o != LAST_STAGE) begin
                            stage_idx_o <= stage_idx_o + 2'd1;
                            state       <= ST_LAUNCH;
                        end else if (layer_idx_o != LAST_LAYER) begin
                            layer_idx_o <= layer_idx_o + 8'd1;
                            stage_idx_o <= 2'd0;
                            state       <= ST_LAUNCH;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end else if (timeout_hit) begin
                        err_o <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (clear_i) begin
                        err_o <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hits seen in the clearing cycle still register so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious_o <= 4'b0000;
        end else if (flag_clear) begin
            spurious_o <= spurious_hits;
        end else begin
            spurious_o <= spurious_o | spurious_hits;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_perf
        assign perf_inc[g] = ((state == ST_LAUNCH) || (state == ST_WAIT)) &&
                             (stage_idx_o == 2'(g));

        sched_sat_counter #(.WIDTH(PERF_W)) u_perf (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (run_accept),
            .inc   (perf_inc[g]),
            .count (perf[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_o <= '0;
        end else begin
            perf_cnt_o <= perf[perf_sel_i];
        end
    end

endmodule

// File: doc/gat_stage_scheduler.md
Name: gat_stage_scheduler

Overview:
Top-level sequencer for the GAT layer datapath. It launches the four compute stages in a fixed order per layer (SPMM -> DMVM -> softmax -> aggregation), waits for each stage's completion, and loops over NUM_LAYERS. It provides a host start/busy/done handshake, a per-stage watchdog, sticky error/spurious flags, and saturating per-stage cycle counters for performance readout. It sits between the host/control interface and the stage start/done strobes.

Parameters:
NUM_LAYERS, 2, number of GAT layers run per start; range 1..255
TIMEOUT_CYCLES, 65535, max cycles a stage may take in WAIT; 0 disables the watchdog
PERF_W, 32, width of the per-stage cycle counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start_i  in  1  host run request, accepted only in IDLE
clear_i  in  1  host clear; releases the ERR state and clears sticky flags
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after the final stage of the final layer completes
err_o  out  1  sticky watchdog timeout flag
layer_idx_o  out  8  current layer index
stage_idx_o  out  2  current stage (0=SPMM, 1=DMVM, 2=SM, 3=AGGR)
stage_start_o  out  4  one-hot, one-cycle start pulse to stage[i]
stage_done_i  in  4  stage[i] completion pulse
spurious_o  out  4  sticky; bit i is set by a done on a non-active stage
perf_sel_i  in  2  selects the stage counter to read
perf_cnt_o  out  PERF_W  registered counter readout; 1-cycle latency

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, LAUNCH, WAIT, FINISH, ERR.
- IDLE:
  - start_i=1 -> clear layer_idx, stage_idx, all perf counters and spurious_o; go to LAUNCH.
  - clear_i in IDLE clears spurious_o.
- LAUNCH (exactly 1 cycle):
  - stage_start_o[stage_idx]=1.
  - Timeout counter loads 0.
  - perf[stage_idx] increments by 1.
  - Go to WAIT.
- WAIT: perf[stage_idx] and the timeout counter increment every cycle, including the cycle in which done arrives.
  - stage_done_i[stage_idx]=1:
    - stage_idx<3 -> stage_idx+1, LAUNCH.
    - else, layer_idx<NUM_LAYERS-1 -> layer_idx+1, stage_idx=0, LAUNCH.
    - else -> FINISH.
  - Timeout counter == TIMEOUT_CYCLES (when nonzero) and no active done in that cycle -> err_o=1, go to ERR. If done and timeout coincide, done wins.
- FINISH (1 cycle): done_o=1, then IDLE. layer_idx_o and stage_idx_o hold their final values until the next accepted start.
- ERR:
  - busy_o stays 1 and no start pulses are issued.
  - clear_i -> err_o=0, spurious_o=0, go to IDLE.
  - start_i is ignored.
- Spurious done: any stage_done_i bit other than the active stage during WAIT, or any bit in IDLE/LAUNCH/FINISH/ERR, sets the matching spurious_o bit. The FSM is unaffected.
- start_i while busy is ignored.
- Perf counters saturate at 2^PERF_W-1 (no wrap) and accumulate across layers.
- Counted stage time = 1 (LAUNCH) + WAIT cycles through and including the done cycle.
- perf_cnt_o <= perf[perf_sel_i] on every clock edge.
- Asynchronous reset mid-run returns to IDLE immediately. No start pulse is emitted in the reset cycle.

Decomposition:
- Package gat_sched_pkg holds:
  - stage_e enum (STG_SPMM, STG_DMVM, STG_SM, STG_AGGR);
  - sched_state_e enum;
  - NUM_STAGES=4.
- Sub-module sched_sat_counter (clear, inc, saturating, width PERF_W), instantiated 4 times for the perf counters.

Test Plan:
- Nominal run: NUM_LAYERS=2, stub stages assert done 3 cycles after their start; start_i at cycle 0.
  - Start pulses on cycles 1, 5, 9, …, 29 in order 0,1,2,3,0,1,2,3.
  - done_o high at cycle 33 only.
  - perf_cnt_o=8 for each perf_sel_i value.
- Watchdog: TIMEOUT_CYCLES=10, DMVM never returns done.
  - err_o rises 10 cycles into DMVM WAIT and stays high; no further start pulses.
  - clear_i -> IDLE, busy_o=0.
- Done/timeout collision: TIMEOUT_CYCLES=4, stage done exactly at timeout count 4 -> advances normally, err_o=0.
- Spurious done: pulse stage_done_i[3] while SPMM is active -> spurious_o=4'b1000, sequence unchanged.
  - Next start_i clears spurious_o to 0.
- Busy start and reset: start_i asserted repeatedly during a run -> single run, one done_o.
  - rst_n low mid-WAIT -> all outputs 0 the same cycle.
  - New start after reset runs cleanly from layer 0.
- Saturation: PERF_W=4, stage latency 20 -> perf counter reads 15 and does not wrap.
